lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_pkg.sv | 51 +++++
 rtl/lfsr_next.sv | 20 ++
 rtl/lfsr_checker.sv | 122 ++++++++++++
 tb/tb_lfsr_checker.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR tap table, checker FSM encoding and counter width
package lfsr_pkg;

  // Width of the saturating mismatch counter
  localparam int ERR_CNT_W = 16;

  // Checker FSM states
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // XNOR feedback taps per width; bit (t-1) set for tap position t
  function automatic logic [31:0] tap_mask(input int n);
    case (n)
      3:       tap_mask = 32'h0000_0006;
      4:       tap_mask = 32'h0000_000C;
      5:       tap_mask = 32'h0000_0014;
      6:       tap_mask = 32'h0000_0030;
      7:       tap_mask = 32'h0000_0060;
      8:       tap_mask = 32'h0000_00B8;
      9:       tap_mask = 32'h0000_0110;
      10:      tap_mask = 32'h0000_0240;
      11:      tap_mask = 32'h0000_0500;
      12:      tap_mask = 32'h0000_0829;
      13:      tap_mask = 32'h0000_100D;
      14:      tap_mask = 32'h0000_2015;
      15:      tap_mask = 32'h0000_6000;
      16:      tap_mask = 32'h0000_D008;
      17:      tap_mask = 32'h0001_2000;
      18:      tap_mask = 32'h0002_0400;
      19:      tap_mask = 32'h0004_0023;
      20:      tap_mask = 32'h0009_0000;
      21:      tap_mask = 32'h0014_0000;
      22:      tap_mask = 32'h0030_0000;
      23:      tap_mask = 32'h0042_0000;
      24:      tap_mask = 32'h00E1_0000;
      25:      tap_mask = 32'h0120_0000;
      26:      tap_mask = 32'h0200_0023;
      27:      tap_mask = 32'h0400_0013;
      28:      tap_mask = 32'h0900_0000;
      29:      tap_mask = 32'h1400_0000;
      30:      tap_mask = 32'h2000_0029;
      31:      tap_mask = 32'h4800_0000;
      32:      tap_mask = 32'h8020_0003;
      default: tap_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational XNOR LFSR step: shift left, feedback into bit 0
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 4
) (
  input  logic [NUM_BITS-1:0] i_Word,
  output logic [NUM_BITS-1:0] o_Next
);

  localparam logic [31:0]         TAPS = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] MASK = TAPS[NUM_BITS-1:0];

  logic w_fb;

  // XNOR of the tap bits keeps all-zeros legal and makes all-ones the lockup word
  assign w_fb   = ~^(i_Word & MASK);
  assign o_Next = {i_Word[NUM_BITS-2:0], w_fb};

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising XNOR LFSR stream checker with flywheel lock
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS   = 4,
  parameter int LOCK_COUNT = 8,
  parameter int ERR_THRESH = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Data_DV,
  input  logic [NUM_BITS-1:0]  i_Data,
  input  logic                 i_Clear_Count,
  output logic                 o_Locked,
  output logic                 o_Error,
  output logic [ERR_CNT_W-1:0] o_Err_Count,
  output logic [NUM_BITS-1:0]  o_Expected
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W   = $clog2(ERR_THRESH + 1);

  state_t               r_state;
  logic [NUM_BITS-1:0]  r_ref;
  logic [MATCH_W-1:0]   r_match_cnt;
  logic [BAD_W-1:0]     r_bad_cnt;
  logic                 r_locked;
  logic                 r_error;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic [NUM_BITS-1:0]  w_next_ref;
  logic                 w_match;
  logic                 w_all_ones;

  lfsr_next #(
    .NUM_BITS(NUM_BITS)
  ) u_next (
    .i_Word(r_ref),
    .o_Next(w_next_ref)
  );

  assign w_match    = (i_Data == w_next_ref);
  assign w_all_ones = &i_Data;

  // Search/verify/lock sequencing, reference tracking and error accounting
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= ST_SEARCH;
      r_ref       <= '0;
      r_match_cnt <= '0;
      r_bad_cnt   <= '0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_error <= 1'b0;
      if (i_Data_DV) begin
        case (r_state)
          ST_SEARCH: begin
            // The lockup word can never come from a running generator, so never seed on it
            if (!w_all_ones) begin
              r_ref       <= i_Data;
              r_match_cnt <= '0;
              r_state     <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            r_ref <= i_Data;
            if (w_match) begin
              if (r_match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                r_state     <= ST_LOCKED;
                r_locked    <= 1'b1;
                r_match_cnt <= '0;
                r_bad_cnt   <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + 1'b1;
              end
            end else begin
              r_match_cnt <= '0;
              if (w_all_ones) begin
                r_state <= ST_SEARCH;
              end
            end
          end
          ST_LOCKED: begin
            // Flywheel: the reference never follows received data once locked
            r_ref <= w_next_ref;
            if (w_match) begin
              r_bad_cnt <= '0;
            end else begin
              r_error <= 1'b1;
              if (r_err_count != {ERR_CNT_W{1'b1}}) begin
                r_err_count <= r_err_count + 1'b1;
              end
              if (r_bad_cnt == BAD_W'(ERR_THRESH - 1)) begin
                r_state   <= ST_SEARCH;
                r_locked  <= 1'b0;
                r_bad_cnt <= '0;
              end else begin
                r_bad_cnt <= r_bad_cnt + 1'b1;
              end
            end
          end
          default: begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
      // Placed last so a clear overrides a same-cycle increment
      if (i_Clear_Count) begin
        r_err_count <= '0;
      end
    end
  end

  assign o_Locked    = r_locked;
  assign o_Error     = r_error;
  assign o_Err_Count = r_err_count;
  assign o_Expected  = r_ref;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed self-checking bench for lfsr_checker (4-bit, defaults)
module tb_lfsr_checker;

  logic        clk;
  logic        rst_n;
  logic        dv;
  logic [3:0]  data;
  logic        clr;
  logic        locked;
  logic        error;
  logic [15:0] err_count;
  logic [3:0]  expected;

  int n_vec;
  int n_err;

  logic [3:0] seq [15] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110,
                           4'b1101, 4'b1011, 4'b0110, 4'b1100, 4'b1001,
                           4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000};

  lfsr_checker #(
    .NUM_BITS(4),
    .LOCK_COUNT(8),
    .ERR_THRESH(4)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .i_Data_DV(dv),
    .i_Data(data),
    .i_Clear_Count(clr),
    .o_Locked(locked),
    .o_Error(error),
    .o_Err_Count(err_count),
    .o_Expected(expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] w, input logic c);
    @(negedge clk);
    dv   = 1'b1;
    data = w;
    clr  = c;
    @(posedge clk);
    #1;
    dv  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      dv = 1'b0;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    dv    = 1'b0;
    data  = 4'b0000;
    clr   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_count", 32'(err_count), 32'd0);
    chk("rst_expected", 32'(expected), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock: seed 0000 plus eight matches
    for (int i = 0; i < 8; i++) send(seq[i], 1'b0);
    chk("lock_not_yet", 32'(locked), 32'd0);
    send(seq[8], 1'b0);
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_count", 32'(err_count), 32'd0);
    chk("lock_expected", 32'(expected), 32'hC);

    // Single corrupt word in place of 1001
    send(4'b0111, 1'b0);
    chk("single_err_pulse", 32'(error), 32'd1);
    chk("single_err_count", 32'(err_count), 32'd1);
    chk("single_err_locked", 32'(locked), 32'd1);
    chk("single_err_flywheel", 32'(expected), 32'h9);
    send(seq[10], 1'b0);
    chk("single_err_recover", 32'(error), 32'd0);
    chk("single_err_count_hold", 32'(err_count), 32'd1);
    chk("single_err_lock_hold", 32'(locked), 32'd1);

    // Clear with no data valid
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clear_idle", 32'(err_count), 32'd0);
    chk("clear_idle_lock", 32'(locked), 32'd1);

    // Loss of lock: four consecutive corrupt words
    for (int i = 11; i < 14; i++) send(seq[i] ^ 4'b0001, 1'b0);
    chk("loss_still_locked", 32'(locked), 32'd1);
    chk("loss_count3", 32'(err_count), 32'd3);
    send(seq[14] ^ 4'b0001, 1'b0);
    chk("loss_unlocked", 32'(locked), 32'd0);
    chk("loss_count4", 32'(err_count), 32'd4);
    chk("loss_err_pulse", 32'(error), 32'd1);

    // Relock from a clean stream; count survives the loss
    for (int i = 0; i < 8; i++) send(seq[i], 1'b0);
    chk("relock_not_yet", 32'(locked), 32'd0);
    send(seq[8], 1'b0);
    chk("relock_locked", 32'(locked), 32'd1);
    chk("relock_count", 32'(err_count), 32'd4);

    // Asynchronous reset mid-lock, checked before any clock edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_locked", 32'(locked), 32'd0);
    chk("async_rst_count", 32'(err_count), 32'd0);
    chk("async_rst_expected", 32'(expected), 32'd0);
    chk("async_rst_error", 32'(error), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Lockup words must not seed a reference
    for (int i = 0; i < 3; i++) send(4'b1111, 1'b0);
    chk("lockup_expected", 32'(expected), 32'd0);
    chk("lockup_locked", 32'(locked), 32'd0);

    // Lock sequence with 3-cycle DV gaps
    for (int i = 0; i < 8; i++) begin
      send(seq[i], 1'b0);
      idle(3);
    end
    chk("gap_hold_expected", 32'(expected), 32'h6);
    chk("gap_not_yet", 32'(locked), 32'd0);
    send(seq[8], 1'b0);
    chk("gap_locked", 32'(locked), 32'd1);
    idle(3);
    #1;
    chk("gap_lock_hold", 32'(locked), 32'd1);
    chk("gap_no_error", 32'(error), 32'd0);

    // Clear priority over a coincident counted error
    send(seq[9] ^ 4'b1000, 1'b0);
    chk("prio_pre_count", 32'(err_count), 32'd1);
    send(seq[10], 1'b0);
    send(seq[11] ^ 4'b1000, 1'b1);
    chk("prio_err_pulse", 32'(error), 32'd1);
    chk("prio_count", 32'(err_count), 32'd0);

    // Saturation from a preloaded count
    @(negedge clk);
    force dut.r_err_count = 16'hFFFE;
    #1;
    release dut.r_err_count;
    send(seq[12], 1'b0);
    send(seq[13] ^ 4'b0010, 1'b0);
    chk("sat_reach", 32'(err_count), 32'hFFFF);
    send(seq[14], 1'b0);
    send(seq[0] ^ 4'b0010, 1'b0);
    chk("sat_hold", 32'(err_count), 32'hFFFF);
    chk("sat_err_pulse", 32'(error), 32'd1);
    chk("sat_locked", 32'(locked), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
